pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 13 +
 rtl/flop_enr.sv | 22 ++
 rtl/pipe_stage.sv | 120 ++++++++++++
 tb/tb_pipe_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage: control state encoding
// and storage depth.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } pipe_state_t;

    localparam int PIPE_SKID_DEPTH = 2;

endpackage : pipe_pkg

// File: rtl/flop_enr.sv
// Payload register with load enable and synchronous reset to a configurable value.
module flop_enr #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over load; without enable the value is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : flop_enr

// File: rtl/pipe_stage.sv
// Two-entry valid/ready pipeline stage: a main register feeding the output and a skid
// register that absorbs one payload so in_ready can be a registered signal.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_t      state;
    pipe_state_t      next_state;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             clear;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign clear    = rst | flush;
    assign main_d   = main_from_skid ? skid_q : in_data;

    // Next-state and register-load decode for the three occupancy states.
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    load_main  = 1'b1;
                    next_state = ST_BUSY;
                end else begin
                    next_state = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        load_skid  = 1'b1;
                        next_state = ST_FULL;
                    end
                    2'b01: begin
                        next_state = ST_EMPTY;
                    end
                    2'b11: begin
                        load_main  = 1'b1;
                        next_state = ST_BUSY;
                    end
                    default: begin
                        next_state = ST_BUSY;
                    end
                endcase
            end
            ST_FULL: begin
                if (out_xfer) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    next_state     = ST_BUSY;
                end else begin
                    next_state = ST_FULL;
                end
            end
            default: begin
                // Unused encoding 2'b11 recovers to empty.
                next_state = ST_EMPTY;
            end
        endcase
    end

    // State plus registered handshake outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_FULL);
            out_valid <= (next_state == ST_BUSY) || (next_state == ST_FULL);
        end
    end

    flop_enr #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main (
        .clk (clk),
        .rst (clear),
        .en  (load_main),
        .d   (main_d),
        .q   (out_data)
    );

    flop_enr #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk (clk),
        .rst (clear),
        .en  (load_skid),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a queue-based model of a 2-entry FIFO predicts
// occupancy, handshake outputs and the order of delivered payloads.
module tb_pipe_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = 32'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    logic [W-1:0] exp_q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    bit           armed  = 1'b0;
    bit           want_zero = 1'b0;

    pipe_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Monitor: retire completed output transfers in order, then apply clears.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_underflow: got %h with no payload expected", out_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL pop_data: got %h expected %h", out_data, e);
                    end
                end
            end
            if (flush) exp_q.delete();
        end
    end

    task automatic check_outputs();
        bit ev;
        bit er;
        ev = (exp_q.size() != 0);
        er = (exp_q.size() < 2);
        n_vec++;
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL out_valid: got %b expected %b", out_valid, ev);
        end
        n_vec++;
        if (in_ready !== er) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, er);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            if (out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL head_data: got %h expected %h", out_data, exp_q[0]);
            end
        end
        if (want_zero) begin
            n_vec++;
            if (out_data !== 32'h0) begin
                n_fail++;
                $display("FAIL rst_val: got %h expected %h", out_data, 32'h0);
            end
            want_zero = 1'b0;
        end
    endtask

    // One cycle: check what the DUT shows, then drive inputs for the next edge.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                        input logic fl, input logic rs);
        @(negedge clk);
        if (armed) check_outputs();
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        if (armed && iv && in_ready && !fl && !rs) exp_q.push_back(id);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with live input; nothing may be captured.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        armed = 1'b1;
        want_zero = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
        idle(3);

        // Backpressure fills both entries, then drains in order.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Flush while full with a competing input.
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        want_zero = 1'b1;
        idle(2);

        // Flush while busy: accepted-looking input must be discarded.
        step(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1E, 1'b0, 1'b1, 1'b0);
        want_zero = 1'b1;
        idle(2);

        // Reset and flush together while full.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
        want_zero = 1'b1;
        idle(2);

        // Random valid/ready traffic with rare flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 127) == 0), 1'b0);
        end
        idle(4);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d payloads left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage
